// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_stage
// Purpose  : EX->MEM pipeline register with valid tracking, a one-entry skid
//            buffer, MEM stall (hold) and flush. in_ready is taken straight
//            from a flop, so MEM stall never reaches EX combinationally.
//            Control outputs are gated with out_valid so bubbles never carry
//            live MemRead/MemWrite/write-back bits.
// Ports    : clk, reset (async, active high)
//            in_valid / in_ready        upstream handshake
//            wb_in, m_in, alu_in, rd_data2_in, rd_addr_in   EX beat fields
//            hold_i, flush_i            MEM stall / pipeline flush
//            out_valid, wb_out, mem_write, mem_read, alu_out,
//            rd_data2_out, rd_addr_out  MEM-side beat
//            skid_full                  skid entry occupied (== !in_ready)
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage #(
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rd_data2_in,
  input  logic [REG_W-1:0]  rd_addr_in,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              out_valid,
  output logic [WB_W-1:0]   wb_out,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rd_data2_out,
  output logic [REG_W-1:0]  rd_addr_out,
  output logic              skid_full
);

  // A beat is packed as {wb, m, alu, rd_data2, rd_addr}, stored verbatim.
  localparam int BEAT_W  = WB_W + M_W + 2 * DATA_W + REG_W;
  localparam int RD_LSB  = 0;
  localparam int D2_LSB  = REG_W;
  localparam int ALU_LSB = REG_W + DATA_W;
  localparam int M_LSB   = REG_W + 2 * DATA_W;
  localparam int WB_LSB  = M_LSB + M_W;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;

  logic              accept;
  logic              drain;
  logic [BEAT_W-1:0] in_beat;

  assign in_beat = {wb_in, m_in, alu_in, rd_data2_in, rd_addr_in};

  // in_ready depends only on the skid flop; accept/drain use state + inputs.
  assign accept = in_valid & ~skid_valid_q;
  assign drain  = main_valid_q & ~hold_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      // Drop everything, including this cycle's incoming beat. Data
      // registers keep stale contents; gating hides them.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // FULL: no accept possible; on drain the skid entry moves up.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      // EMPTY, or ONE with the current beat leaving: main takes the input.
      main_valid_d = accept;
      if (accept) begin
        main_d = in_beat;
      end
    end else if (accept) begin
      // ONE under hold: park the new beat in the skid entry.
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready     = ~skid_valid_q;
  assign skid_full    = skid_valid_q;
  assign out_valid    = main_valid_q;

  assign wb_out       = main_q[WB_LSB +: WB_W] & {WB_W{main_valid_q}};
  assign mem_write    = main_q[M_LSB + 1] & main_valid_q;
  assign mem_read     = main_q[M_LSB] & main_valid_q;

  assign alu_out      = main_q[ALU_LSB +: DATA_W];
  assign rd_data2_out = main_q[D2_LSB +: DATA_W];
  assign rd_addr_out  = main_q[RD_LSB +: REG_W];

endmodule
`default_nettype wire
